// File: rtl/alu_issue.sv
// Issue/writeback stage around a combinational ALU: instruction FIFO, 8x16 register file,
// three-state issue FSM and local carry/overflow generation.
module alu_issue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [5:0]   in_opcode,
   input  logic [2:0]   in_dst,
   input  logic [2:0]   in_src1,
   input  logic [2:0]   in_src2,
   input  logic         in_imm_sel,
   input  logic [W-1:0] in_imm,
   output logic         alu_enable,
   output logic [5:0]   alu_opcode,
   output logic [W-1:0] alu_term1,
   output logic [W-1:0] alu_term2,
   input  logic [W-1:0] alu_result,
   input  logic         alu_fl_zero,
   input  logic         alu_fl_negative,
   output logic         wb_valid,
   output logic [2:0]   wb_dst,
   output logic [W-1:0] wb_data,
   output logic [3:0]   flags,
   output logic         err_div0,
   input  logic [2:0]   dbg_addr,
   output logic [W-1:0] dbg_data
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] Full = (AW+1)'(DEPTH);

   localparam logic [5:0] OpAdd = 6'b000000;
   localparam logic [5:0] OpSub = 6'b000001;
   localparam logic [5:0] OpDiv = 6'b000011;
   localparam logic [5:0] OpMod = 6'b000100;
   localparam logic [5:0] OpCmp = 6'b001001;
   localparam logic [5:0] OpTst = 6'b001111;
   localparam logic [5:0] OpInc = 6'b010000;
   localparam logic [5:0] OpDec = 6'b010001;

   typedef enum logic [1:0] {StIdle, StIssue, StCapture} state_e;

   state_e state_q, state_d;
   logic   pop, commit, push;

   logic [5:0]   q_opcode  [DEPTH];
   logic [2:0]   q_dst     [DEPTH];
   logic [2:0]   q_src1    [DEPTH];
   logic [2:0]   q_src2    [DEPTH];
   logic         q_imm_sel [DEPTH];
   logic [W-1:0] q_imm     [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic [W-1:0] regs [8];
   logic [2:0]   iss_dst;

   logic [W:0]   sum;
   logic [W-1:0] diff;
   logic         c_flag, v_flag, is_div0, writes_reg;

   assign in_ready = (count != Full);
   assign push     = in_valid && in_ready;
   assign dbg_data = regs[dbg_addr];

   // Payload storage needs no reset: pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         q_opcode[wr_ptr]  <= in_opcode;
         q_dst[wr_ptr]     <= in_dst;
         q_src1[wr_ptr]    <= in_src1;
         q_src2[wr_ptr]    <= in_src2;
         q_imm_sel[wr_ptr] <= in_imm_sel;
         q_imm[wr_ptr]     <= in_imm;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count != '0) begin
               pop     = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue:   state_d = StCapture;
         StCapture: begin
            commit  = 1'b1;
            state_d = StIdle;
         end
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Carry/overflow are derived from the held ALU terms, not from the ALU itself.
   always_comb begin
      sum    = {1'b0, alu_term1} + {1'b0, alu_term2};
      diff   = alu_term1 - alu_term2;
      c_flag = 1'b0;
      v_flag = 1'b0;
      case (alu_opcode)
         OpAdd: begin
            c_flag = sum[W];
            v_flag = (alu_term1[W-1] == alu_term2[W-1]) && (sum[W-1] != alu_term1[W-1]);
         end
         OpSub, OpCmp: begin
            c_flag = (alu_term1 < alu_term2);
            v_flag = (alu_term1[W-1] != alu_term2[W-1]) && (diff[W-1] != alu_term1[W-1]);
         end
         OpInc: begin
            c_flag = &alu_term1;
            v_flag = (alu_term1 == {1'b0, {(W-1){1'b1}}});
         end
         OpDec: begin
            c_flag = ~|alu_term1;
            v_flag = (alu_term1 == {1'b1, {(W-1){1'b0}}});
         end
         default: ;
      endcase
      is_div0    = ((alu_opcode == OpDiv) || (alu_opcode == OpMod)) && (alu_term2 == '0);
      writes_reg = !((alu_opcode == OpCmp) || (alu_opcode == OpTst));
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         alu_enable <= 1'b0;
         alu_opcode <= '0;
         alu_term1  <= '0;
         alu_term2  <= '0;
         iss_dst    <= '0;
         wb_valid   <= 1'b0;
         wb_dst     <= '0;
         wb_data    <= '0;
         flags      <= '0;
         err_div0   <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         wb_valid <= 1'b0;
         if (pop) begin
            alu_enable <= 1'b1;
            alu_opcode <= q_opcode[rd_ptr];
            iss_dst    <= q_dst[rd_ptr];
            alu_term1  <= regs[q_src1[rd_ptr]];
            alu_term2  <= q_imm_sel[rd_ptr] ? q_imm[rd_ptr] : regs[q_src2[rd_ptr]];
         end
         if (commit) begin
            alu_enable <= 1'b0;
            if (is_div0) begin
               err_div0 <= 1'b1;
            end else begin
               flags <= {alu_fl_zero, alu_fl_negative, c_flag, v_flag};
               if (writes_reg) begin
                  regs[iss_dst] <= alu_result;
                  wb_valid      <= 1'b1;
                  wb_dst        <= iss_dst;
                  wb_data       <= alu_result;
               end
            end
         end
      end
   end

endmodule
